// File: rtl/aq_vidu_vid_fp_dis_ctrl_if.sv
// aq_vidu_vid_fp_dis_ctrl_if: splitter/datapath/VPU signals seen by the FP dispatch controller
interface aq_vidu_vid_fp_dis_ctrl_if;
  logic       rtu_yy_xx_flush;
  logic       split_ctrl_fp_inst_vld;
  logic       fgpr_reuse_req;
  logic       fgpr_reuse_dstf_vld;
  logic       dp_ctrl_dis_fp_inst_srcf0_vld;
  logic       dp_ctrl_dis_fp_inst_srcf1_vld;
  logic       dp_ctrl_dis_fp_inst_srcf2_vld;
  logic [4:0] dp_ctrl_dis_fp_inst_srcf0_reg;
  logic [4:0] dp_ctrl_dis_fp_inst_srcf1_reg;
  logic [4:0] dp_ctrl_dis_fp_inst_srcf2_reg;
  logic       dp_ctrl_dis_fp_inst_dstf_vld;
  logic [4:0] dp_wbt_fp_dstv_reg;
  logic       dp_ctrl_dis_fp_inst_wb_type;
  logic       dp_ctrl_dis_fp_inst_vlsu_stall;
  logic       vpu_vidu_fp_fwd_vld;
  logic [4:0] vpu_vidu_fp_fwd_reg;
  logic       vpu_vidu_fp_wb_vld;
  logic [4:0] vpu_vidu_fp_wb_reg;
  logic       vpu_vidu_vid_fp_inst_rdy;
  logic       ctrl_dp_fgpr_reuse_inst_dp_vld;
  logic       vidu_vpu_vid_fp_inst_vld;
  logic       ctrl_split_fp_inst_stall;
  logic [2:0] wbt_ctrl_fp_srcv2_info;
  logic       fp_sb_busy;
  modport master (
    output rtu_yy_xx_flush, split_ctrl_fp_inst_vld, fgpr_reuse_req, fgpr_reuse_dstf_vld,
           dp_ctrl_dis_fp_inst_srcf0_vld, dp_ctrl_dis_fp_inst_srcf1_vld, dp_ctrl_dis_fp_inst_srcf2_vld,
           dp_ctrl_dis_fp_inst_srcf0_reg, dp_ctrl_dis_fp_inst_srcf1_reg, dp_ctrl_dis_fp_inst_srcf2_reg,
           dp_ctrl_dis_fp_inst_dstf_vld, dp_wbt_fp_dstv_reg, dp_ctrl_dis_fp_inst_wb_type,
           dp_ctrl_dis_fp_inst_vlsu_stall, vpu_vidu_fp_fwd_vld, vpu_vidu_fp_fwd_reg,
           vpu_vidu_fp_wb_vld, vpu_vidu_fp_wb_reg, vpu_vidu_vid_fp_inst_rdy,
    input  ctrl_dp_fgpr_reuse_inst_dp_vld, vidu_vpu_vid_fp_inst_vld, ctrl_split_fp_inst_stall,
           wbt_ctrl_fp_srcv2_info, fp_sb_busy
  );
  modport slave (
    input  rtu_yy_xx_flush, split_ctrl_fp_inst_vld, fgpr_reuse_req, fgpr_reuse_dstf_vld,
           dp_ctrl_dis_fp_inst_srcf0_vld, dp_ctrl_dis_fp_inst_srcf1_vld, dp_ctrl_dis_fp_inst_srcf2_vld,
           dp_ctrl_dis_fp_inst_srcf0_reg, dp_ctrl_dis_fp_inst_srcf1_reg, dp_ctrl_dis_fp_inst_srcf2_reg,
           dp_ctrl_dis_fp_inst_dstf_vld, dp_wbt_fp_dstv_reg, dp_ctrl_dis_fp_inst_wb_type,
           dp_ctrl_dis_fp_inst_vlsu_stall, vpu_vidu_fp_fwd_vld, vpu_vidu_fp_fwd_reg,
           vpu_vidu_fp_wb_vld, vpu_vidu_fp_wb_reg, vpu_vidu_vid_fp_inst_rdy,
    output ctrl_dp_fgpr_reuse_inst_dp_vld, vidu_vpu_vid_fp_inst_vld, ctrl_split_fp_inst_stall,
           wbt_ctrl_fp_srcv2_info, fp_sb_busy
  );
endinterface

// File: rtl/aq_vidu_vid_fp_dis_ctrl.sv
// aq_vidu_vid_fp_dis_ctrl: FGPR read-port arbitration, pending-write scoreboard and FP dispatch valid
module aq_vidu_vid_fp_dis_ctrl #(
  parameter int STARVE_LMT = 4
) (
  input logic                      forever_cpuclk,
  input logic                      cpurst_b,
  aq_vidu_vid_fp_dis_ctrl_if.slave dis
);
  logic [31:0] pend, pend_type, set_mask, clr_mask;
  logic [2:0]  starve_cnt;
  logic        split, flush, gnt, src0_ok, src1_ok, src2_ok, waw, vld, fire, set_en, set_type;
  logic [4:0]  r0, r1, r2, dst;
  always_comb begin
    split    = dis.split_ctrl_fp_inst_vld;
    flush    = dis.rtu_yy_xx_flush;
    r0       = dis.dp_ctrl_dis_fp_inst_srcf0_reg;
    r1       = dis.dp_ctrl_dis_fp_inst_srcf1_reg;
    r2       = dis.dp_ctrl_dis_fp_inst_srcf2_reg;
    dst      = dis.dp_wbt_fp_dstv_reg;
    gnt      = dis.fgpr_reuse_req & ~flush & ~(split & (starve_cnt == 3'(STARVE_LMT)));
    src0_ok  = ~dis.dp_ctrl_dis_fp_inst_srcf0_vld | ~pend[r0]
             | (dis.vpu_vidu_fp_fwd_vld & (dis.vpu_vidu_fp_fwd_reg == r0) & ~pend_type[r0]);
    src1_ok  = ~dis.dp_ctrl_dis_fp_inst_srcf1_vld | ~pend[r1]
             | (dis.vpu_vidu_fp_fwd_vld & (dis.vpu_vidu_fp_fwd_reg == r1) & ~pend_type[r1]);
    // srcf2 is read late in execute, so only long-latency producers block it
    src2_ok  = ~dis.dp_ctrl_dis_fp_inst_srcf2_vld | ~(pend[r2] & pend_type[r2]);
    waw      = dis.dp_ctrl_dis_fp_inst_dstf_vld & pend[dst] & pend_type[dst];
    vld      = split & ~gnt & src0_ok & src1_ok & src2_ok & ~waw
             & ~dis.dp_ctrl_dis_fp_inst_vlsu_stall & ~flush;
    fire     = vld & dis.vpu_vidu_vid_fp_inst_rdy;
    set_en   = (fire & dis.dp_ctrl_dis_fp_inst_dstf_vld) | (gnt & dis.fgpr_reuse_dstf_vld);
    set_type = fire & dis.dp_ctrl_dis_fp_inst_wb_type;
    set_mask = set_en ? 32'd1 << dst : '0;
    clr_mask = dis.vpu_vidu_fp_wb_vld ? 32'd1 << dis.vpu_vidu_fp_wb_reg : '0;
    dis.ctrl_dp_fgpr_reuse_inst_dp_vld = gnt;
    dis.vidu_vpu_vid_fp_inst_vld       = vld;
    dis.ctrl_split_fp_inst_stall       = split & ~fire;
    dis.wbt_ctrl_fp_srcv2_info         = {pend_type[r2], pend[r2], ~pend[r2]};
    dis.fp_sb_busy                     = |pend;
  end
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      pend       <= '0;
      pend_type  <= '0;
      starve_cnt <= '0;
    end else if (flush) begin
      pend       <= '0;
      pend_type  <= '0;
      starve_cnt <= '0;
    end else begin
      pend       <= (pend & ~clr_mask) | set_mask;
      pend_type  <= (pend_type & ~clr_mask & ~set_mask) | (set_type ? set_mask : '0);
      starve_cnt <= (~split | fire) ? '0 : gnt ? starve_cnt + 3'd1 : starve_cnt;
    end
  end
endmodule

// File: doc/aq_vidu_vid_fp_dis_ctrl.md
Name: aq_vidu_vid_fp_dis_ctrl

Overview:
- Dispatch controller for the VIDU FP/vector-scalar dispatch datapath.
- Shares the FGPR read ports between split FP instructions and FGPR-reuse requests, with starvation protection for the split instruction.
- Keeps a 32-entry FGPR pending-write scoreboard, checks source/destination hazards, and produces the dispatch valid and splitter back-pressure.
- Sits between the splitter and the FP dispatch datapath, next to the VPU.

Parameters:
- STARVE_LMT, 4: consecutive cycles a valid split instruction may lose to reuse before it is forced through. Legal range 1..7.

Ports:
- forever_cpuclk  in  1  clock
- cpurst_b  in  1  async active-low reset
- rtu_yy_xx_flush  in  1  pipeline flush
- split_ctrl_fp_inst_vld  in  1  split FP instruction valid
- fgpr_reuse_req  in  1  reuse request; held until granted
- fgpr_reuse_dstf_vld  in  1  reuse op writes an FGPR
- dp_ctrl_dis_fp_inst_srcf{0,1,2}_vld  in  1 each  muxed source valids
- dp_ctrl_dis_fp_inst_srcf{0,1,2}_reg  in  5 each  muxed source indices
- dp_ctrl_dis_fp_inst_dstf_vld  in  1  destination valid
- dp_wbt_fp_dstv_reg  in  5  destination index
- dp_ctrl_dis_fp_inst_wb_type  in  1  1 = VLSU-type (long-latency) producer
- dp_ctrl_dis_fp_inst_vlsu_stall  in  1  store blocked by LSU
- vpu_vidu_fp_fwd_vld / vpu_vidu_fp_fwd_reg  in  1 / 5  forward bus
- vpu_vidu_fp_wb_vld / vpu_vidu_fp_wb_reg  in  1 / 5  FGPR writeback
- vpu_vidu_vid_fp_inst_rdy  in  1  VPU accepts dispatch
- ctrl_dp_fgpr_reuse_inst_dp_vld  out  1  reuse grant; steers datapath muxes
- vidu_vpu_vid_fp_inst_vld  out  1  dispatch valid
- ctrl_split_fp_inst_stall  out  1  splitter hold
- wbt_ctrl_fp_srcv2_info  out  3  {type, pend, vld} of srcf2 register
- fp_sb_busy  out  1  any pending bit set

Behaviour:
- Reset:
  - pend[31:0]=0, type[31:0]=0, starve_cnt=0.
  - All outputs 0 except ctrl_split_fp_inst_stall, which follows inputs combinationally (0 when split_vld=0).
- Reuse grant (combinational):
  - gnt_reuse = fgpr_reuse_req & !flush & !(split_vld & starve_cnt==STARVE_LMT).
  - gnt_reuse does not depend on register indices; no combinational loop through the datapath mux.
- Source hazards:
  - src_ok(n) = !vld | !pend[reg] | (fwd_vld & fwd_reg==reg & !type[reg]).
  - srcf0 and srcf1 must be ok.
  - srcf2 may still be pending unless type[reg]=1, because it can be forwarded in execute.
- Destination hazard (WAW): blocked when dstf_vld & pend[dst] & type[dst].
- Dispatch:
  - vidu_vpu_vid_fp_inst_vld = split_vld & !gnt_reuse & all hazards clear & !vlsu_stall & !flush.
  - fire = inst_vld & vpu_rdy.
  - ctrl_split_fp_inst_stall = split_vld & !fire.
- Scoreboard set:
  - On fire & dstf_vld: pend[dst]<=1, type[dst]<=wb_type.
  - On gnt_reuse & fgpr_reuse_dstf_vld: pend[dst]<=1, type[dst]<=0.
  - Set and clear both take effect on the next edge.
- Scoreboard clear:
  - vpu_vidu_fp_wb_vld clears pend[wb_reg] and type[wb_reg].
  - If set and clear hit the same index in one cycle, set wins.
  - Writeback is not bypassed into the same-cycle hazard check; the forward bus covers that case.
- Starvation counter:
  - Increments when split_vld & gnt_reuse, saturating at STARVE_LMT.
  - Clears on fire or when !split_vld.
  - At STARVE_LMT reuse is denied; it resumes on the cycle after the split instruction fires.
- wbt_ctrl_fp_srcv2_info = {type[srcf2_reg], pend[srcf2_reg], !pend[srcf2_reg]}. Bit0 is the WB_VEC_VLD "data ready" flag.
- Flush:
  - Clears all pend/type bits and starve_cnt on the next edge.
  - Forces vld and grant to 0 in the flush cycle.
  - A writeback arriving during flush is ignored.
- Async reset mid-operation: immediate return to reset state; no partial scoreboard update survives.
- fp_sb_busy = |pend.

Test Plan:
- Scoreboard set, hold and release:
  - Dispatch f5 dst (wb_type=0), rdy=1 → pend[5]=1 next cycle.
  - Next inst srcf0=f5, no fwd → vld=0, stall=1.
  - wb_reg=5 → vld=1 the following cycle.
- Forwarding rules:
  - pend[7]=1 type 0, fwd_vld=1 fwd_reg=7, srcf1=f7 → vld=1 same cycle.
  - Same with type[7]=1 → vld=0.
- Starvation limit:
  - reuse_req held high, split_vld high, STARVE_LMT=4 → grant high for 4 cycles, then low in cycle 5 with inst_vld=1.
  - Grant returns in cycle 6.
- Set/clear collision:
  - fire with dst=f3 while wb_reg=3 → pend[3]=1 afterwards.
- VLSU stall and srcf2:
  - vlsu_stall=1 → vld=0, stall=1, starve_cnt unchanged.
  - srcf2 pending type 0 → vld=1, srcv2_info=3'b010.
- Flush:
  - Pend set on f1, f2, f9, then flush pulse → fp_sb_busy=0 next cycle.
  - No grant or vld in the flush cycle.
  - Reset asserted mid-stall → all state 0 immediately.
